dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words; must be a power of two >= 4.
REQ-002 SHALL have parameter READ_LATENCY, default 2, cycles from read request to read_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port address  input  32  byte address from core MEM stage.
REQ-006 SHALL have port write_data  input  32  store data, lane-0 aligned (unshifted).
REQ-007 SHALL have port write_enable  input  1  store request, one word per cycle.
REQ-008 SHALL have port write_mask  input  4  byte enables, lane-0 aligned: 0001 byte, 0011 half, 1111 word.
REQ-009 SHALL have port read_enable  input  1  load request; held high by core until read_valid.
REQ-010 SHALL have port read_data  output  32  load data, right-aligned to lane 0.
REQ-011 SHALL have port read_valid  output  1  one-cycle pulse; read_data valid in the same cycle.
REQ-012 SHALL have port err  output  1  sticky range error; present only when DMEM_RANGE_CHECK_EN is defined.

Function
REQ-013 SHALL use word index address[AW+1:2], AW=log2(DEPTH_WORDS), and byte offset off=address[1:0].
REQ-014 SHALL perform a store at each rising edge with write_enable=1: effective mask = (write_mask << off) truncated to 4 bits; data = write_data << 8*off; lanes shifted past lane 3 are dropped.
REQ-015 SHALL complete stores in zero cycles with no acknowledge; stores never stall.
REQ-016 SHALL implement read FSM states IDLE and BUSY with a 4-bit down counter.
REQ-017 IDLE: read_enable=1 at an edge SHALL latch address, load counter=READ_LATENCY-1 and go to BUSY; if READ_LATENCY=1, go directly to response.
REQ-018 BUSY: counter SHALL decrement each edge; at the edge where counter=0 with read_enable still 1, read_data SHALL be loaded and read_valid set for exactly one cycle, and state SHALL return to IDLE.
REQ-019 Timing: request first high in cycle t SHALL produce read_valid=1 in cycle t+READ_LATENCY exactly.
REQ-020 read_data SHALL equal (mem[latched index] >> 8*latched off) with upper bits zero-filled; sign extension is the core's job.
REQ-021 read_data SHALL reflect all stores committed at edges before the loading edge; a store at the loading edge itself is not visible.
REQ-022 read_enable=1 in the cycle after read_valid SHALL start a new request (back-to-back loads supported).
REQ-023 read_enable falling while BUSY SHALL abort: return to IDLE, no read_valid, read_data unchanged.
REQ-024 read_enable and write_enable both high SHALL perform the store and start the read independently.
REQ-025 read_valid SHALL be 0 in every cycle not specified by REQ-018; read_data SHALL hold its last value between responses.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, counter=0, read_valid=0, read_data=32'h0, and err=0 when present.
REQ-027 Reset during BUSY SHALL discard the pending read; no read_valid until a new request after reset release.
REQ-028 Memory contents SHALL NOT be reset; stores SHALL be suppressed while rst=1.

Configuration
REQ-029 With DMEM_RANGE_CHECK_EN defined: address[31:AW+2]!=0 SHALL suppress the store, return read_data=32'h0 with the normal read_valid timing, and set err until reset.
REQ-030 Without DMEM_RANGE_CHECK_EN: no err port; high address bits ignored; index wraps modulo DEPTH_WORDS.

Verification
REQ-031 READ_LATENCY=2; word store 0xDEADBEEF mask 1111 at 0x10; read 0x10 first high cycle t -> read_valid only in t+2, read_data=0xDEADBEEF.
REQ-032 Byte store data 0x000000AA mask 0001 at 0x13 over 0x11223344 -> word=0xAA223344; read 0x13 -> 0x000000AA; read 0x12 with 0011 store 0xBEEF -> word=0xBEEF3344.
REQ-033 Two back-to-back reads of 0x0 and 0x4 (read_enable held) -> two read_valid pulses READ_LATENCY+1 cycles apart, correct data for each.
REQ-034 rst pulse in cycle t+1 of a pending read -> read_valid never asserts for it; read_data=0 after reset.
REQ-035 read_enable dropped at t+1 (READ_LATENCY=3) -> no read_valid; new read at t+3 -> read_valid at t+6.
REQ-036 DMEM_RANGE_CHECK_EN, DEPTH_WORDS=1024: store to 0x1000 -> memory unchanged, err=1 next cycle; read 0x1000 -> read_data=0 with read_valid on time; without macro, 0x1000 aliases 0x0.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory for a pipelined core: zero-cycle byte-masked stores and
// fixed-latency loads. Define DMEM_RANGE_CHECK_EN to add the sticky err output.
module dmem_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    input  logic        read_enable,
    output logic [31:0] read_data,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        err,
`endif
    output logic        read_valid,
    output logic        dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] ridx_q, ridx_d;
    logic [1:0]    roff_q, roff_d;
    logic          rbad_q, rbad_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [3:0]    wmask_sh;
    logic [31:0]   wdata_sh;
    logic          addr_bad;
    logic          start;
    logic          respond;
    logic [AW-1:0] resp_idx;
    logic [1:0]    resp_off;
    logic          resp_bad;

    always_comb begin
        idx      = address[AW+1:2];
        off      = address[1:0];
        wmask_sh = write_mask << off;
        wdata_sh = write_data << {off, 3'b000};
    end

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_bad = |address[31:AW+2];
    assign err      = err_q;
`else
    logic unused_range_bits;
    assign addr_bad          = 1'b0;
    assign unused_range_bits = ^{address[31:AW+2], err_q};
`endif

    // Handshake: read_enable is held high by the core until read_valid pulses for one
    // cycle; the enable still high in that valid cycle is not a new request, and
    // dropping it before the response cancels the load silently.
    assign start      = (state_q == IDLE) && read_enable && !rvalid_q;
    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;
    assign dbg_state  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The response fires on the edge that takes the counter to zero, which lands
    // read_valid exactly READ_LATENCY cycles after the request first appeared.
    always_comb begin
        state_d = state_q;
        respond = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (READ_LATENCY == 1) begin
                        respond = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!read_enable) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    respond = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        ridx_d   = ridx_q;
        roff_d   = roff_q;
        rbad_d   = rbad_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        resp_idx = (state_q == IDLE) ? idx : ridx_q;
        resp_off = (state_q == IDLE) ? off : roff_q;
        resp_bad = (state_q == IDLE) ? addr_bad : rbad_q;
        if (start) begin
            cnt_d  = CNT_INIT;
            ridx_d = idx;
            roff_d = off;
            rbad_d = addr_bad;
        end else if (state_q == BUSY) begin
            cnt_d = read_enable ? (cnt_q - 4'd1) : 4'd0;
        end
        if (respond) begin
            rvalid_d = 1'b1;
            rdata_d  = resp_bad ? 32'h0 : (mem[resp_idx] >> {resp_off, 3'b000});
        end
        if (addr_bad && (start || write_enable)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            ridx_q   <= '0;
            roff_q   <= 2'd0;
            rbad_q   <= 1'b0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ridx_q   <= ridx_d;
            roff_q   <= roff_d;
            rbad_q   <= rbad_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Storage is never cleared; reset only blocks stores while it is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && write_enable && !addr_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_sh[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level memory model with cycle-numbered load timing,
// checked every cycle, plus directed loads with literal expected data and latency.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        write_enable = 1'b0;
  logic [3:0]  write_mask = 4'h0;
  logic        read_enable = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        dbg_state;
`ifdef DMEM_RANGE_CHECK_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .write_mask   (write_mask),
    .read_enable  (read_enable),
    .read_data    (read_data),
`ifdef DMEM_RANGE_CHECK_EN
    .err          (err),
`endif
    .read_valid   (read_valid),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- checks ----------------
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic        pend;
    int          start;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic        err;
  } mstate_t;

  mstate_t    m_q = '{1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0};
  logic [7:0] mem_m [DEPTH*4];

  function automatic logic out_of_range(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a >> (AW + 2)) != 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int byte_base(input logic [31:0] a);
    return (int'(a >> 2) % DEPTH) * 4;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] a);
    logic [31:0] w;
    int b;
    if (out_of_range(a)) return 32'h0;
    b = byte_base(a);
    w = {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
    return w >> (8 * int'(a[1:0]));
  endfunction

  // A load requested in cycle c answers in cycle c+LAT unless the enable drops first.
  function automatic mstate_t step(input mstate_t s, input int c);
    mstate_t n;
    n = s;
    n.valid = 1'b0;
    if (!s.pend && read_enable && !s.valid) begin
      n.pend  = 1'b1;
      n.start = c;
      n.addr  = address;
      if (out_of_range(address)) n.err = 1'b1;
    end
    if (n.pend) begin
      if (!read_enable) begin
        n.pend = 1'b0;
      end else if (c + 1 == n.start + LAT) begin
        n.valid = 1'b1;
        n.data  = load_model(n.addr);
        n.pend  = 1'b0;
      end
    end
    if (write_enable && out_of_range(address)) n.err = 1'b1;
    return n;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_q <= '{1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0};
    end else begin
      m_q <= step(m_q, cyc);
      if (write_enable && !out_of_range(address)) begin
        for (int i = 0; i < 4; i++) begin
          if (write_mask[i] && (int'(address[1:0]) + i) < 4)
            mem_m[byte_base(address) + int'(address[1:0]) + i] <= write_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst) begin
        chk1("reset valid", read_valid, 1'b0);
        chk32("reset data", read_data, 32'h0);
      end else begin
        chk1("model valid", read_valid, m_q.valid);
        chk32("model data", read_data, m_q.data);
      end
`ifdef DMEM_RANGE_CHECK_EN
      chk1("model err", err, rst ? 1'b0 : m_q.err);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(posedge clk); #1;
    address = a; write_data = d; write_mask = m; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic wait_valid(output int vc, output logic [31:0] vd, output logic ok);
    int i;
    ok = 1'b0; vc = 0; vd = 32'h0; i = 0;
    while (!ok && i < 40) begin
      @(negedge clk);
      if (read_valid === 1'b1) begin
        vc = cyc; vd = read_data; ok = 1'b1;
      end
      i++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL read_valid timeout: got no pulse want one within 40 cycles");
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    int t, vc;
    logic [31:0] vd;
    logic ok;
    @(posedge clk); #1;
    address = a; read_enable = 1'b1; t = cyc;
    wait_valid(vc, vd, ok);
    if (ok) begin
      chk_int({name, " latency"}, vc - t, LAT);
      chk32({name, " data"}, vd, exp);
    end
    @(posedge clk); #1;
    read_enable = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t, v1, v2;
    logic [31:0] vd;
    logic ok;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk32("reset read_data", read_data, 32'h0);
    chk1("reset read_valid", read_valid, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
    chk1("reset err", err, 1'b0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    wr(32'h10, 32'hDEADBEEF, 4'b1111);
    rd(32'h10, 32'hDEADBEEF, "word load");

    wr(32'h10, 32'h11223344, 4'b1111);
    wr(32'h13, 32'h000000AA, 4'b0001);
    rd(32'h10, 32'hAA223344, "byte merge");
    rd(32'h13, 32'h000000AA, "byte load");
    wr(32'h12, 32'h0000BEEF, 4'b0011);
    rd(32'h10, 32'hBEEF3344, "half merge");
    rd(32'h12, 32'h0000BEEF, "half load");
    wr(32'h13, 32'h0000CAFE, 4'b0011);
    rd(32'h10, 32'hFEEF3344, "half lane drop");
    rd(32'h11, 32'h00FEEF33, "offset 1 load");

    // back-to-back loads with read_enable held
    wr(32'h0, 32'h01020304, 4'b1111);
    wr(32'h4, 32'hA5A5A5A5, 4'b1111);
    @(posedge clk); #1;
    address = 32'h0; read_enable = 1'b1;
    wait_valid(v1, vd, ok);
    if (ok) chk32("b2b first data", vd, 32'h01020304);
    @(posedge clk); #1;
    address = 32'h4;
    wait_valid(v2, vd, ok);
    if (ok) begin
      chk32("b2b second data", vd, 32'hA5A5A5A5);
      chk_int("b2b spacing", v2 - v1, LAT + 1);
    end
    @(posedge clk); #1;
    read_enable = 1'b0;

    // abort, then a fresh request two cycles later
    @(posedge clk); #1;
    address = 32'h10; read_enable = 1'b1;
    @(posedge clk); #1;
    read_enable = 1'b0;
    @(negedge clk);
    chk1("abort no valid t+1", read_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort no valid t+2", read_valid, 1'b0);
    chk32("abort data held", read_data, 32'hA5A5A5A5);
    @(posedge clk); #1;
    address = 32'h0; read_enable = 1'b1; t = cyc;
    wait_valid(v1, vd, ok);
    if (ok) begin
      chk_int("after abort latency", v1 - t, LAT);
      chk32("after abort data", vd, 32'h01020304);
    end
    @(posedge clk); #1;
    read_enable = 1'b0;

    // reset in the cycle after a request; a store during reset must not land
    @(posedge clk); #1;
    address = 32'h0; read_enable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; read_enable = 1'b0;
    address = 32'h4; write_data = 32'hFFFFFFFF; write_mask = 4'b1111; write_enable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; write_enable = 1'b0;
    for (int k = 0; k < 2 * LAT + 3; k++) begin
      @(negedge clk);
      chk1("post-reset no valid", read_valid, 1'b0);
      chk32("post-reset data", read_data, 32'h0);
    end
    rd(32'h4, 32'hA5A5A5A5, "store during reset");

    // store alongside a load: the start-edge store is seen, the loading-edge one is not
    wr(32'h20, 32'h11111111, 4'b1111);
    @(posedge clk); #1;
    address = 32'h20; read_enable = 1'b1;
    write_data = 32'h22222222; write_mask = 4'b1111; write_enable = 1'b1; t = cyc;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); #1;
      write_data = 32'h33333333;
    end
    if (LAT == 1) write_enable = 1'b0;
    wait_valid(v1, vd, ok);
    if (ok) begin
      chk_int("concurrent latency", v1 - t, LAT);
      chk32("concurrent data", vd, (LAT == 1) ? 32'h11111111 : 32'h22222222);
    end
    @(posedge clk); #1;
    read_enable = 1'b0; write_enable = 1'b0;
    rd(32'h20, (LAT == 1) ? 32'h22222222 : 32'h33333333, "after concurrent");

    // address 0x1000 is just past a 1024-word memory
    wr(32'h1000, 32'h5A5A0FF0, 4'b1111);
`ifdef DMEM_RANGE_CHECK_EN
    @(negedge clk);
    chk1("range err set", err, 1'b1);
    rd(32'h0, 32'h01020304, "range store suppressed");
    rd(32'h1000, 32'h0, "range load zero");
    @(negedge clk);
    chk1("range err sticky", err, 1'b1);
`else
    rd(32'h0, 32'h5A5A0FF0, "alias load");
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
